sdram_responder: RTL

Synthesizable single-clock SDRAM device responder: decodes the command/address/data pins a controller drives toward an SDRAM chip and answers as the chip would, backed by a small on-chip array. It sits on the device side of the `dram_*` bus in simulation and on-FPGA loopback builds. This lets the SDRAM controller and test logic be exercised without the external part, and it flags protocol violations for debug.

---
 rtl/sdram_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM device model that decodes controller commands and answers from an on-chip array
// Ports: dram_clk/reset clock and sync reset; dram_cke/cs_n/ras_n/cas_n/we_n/ba/addr command bus;
// dram_ldqm/udqm byte masks; dram_dq_in write data; dram_dq_out/dram_dq_oe read data and drive enable;
// mode_reg last mode value; refresh_count AUTO REFRESH tally; error/error_code sticky first protocol error.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic        dram_clk,
  input  logic        reset,
  input  logic        dram_cke,
  input  logic        dram_cs_n,
  input  logic        dram_ras_n,
  input  logic        dram_cas_n,
  input  logic        dram_we_n,
  input  logic [1:0]  dram_ba,
  input  logic [12:0] dram_addr,
  input  logic        dram_ldqm,
  input  logic        dram_udqm,
  input  logic [15:0] dram_dq_in,
  output logic [15:0] dram_dq_out,
  output logic        dram_dq_oe,
  output logic [12:0] mode_reg,
  output logic [15:0] refresh_count,
  output logic        error,
  output logic [3:0]  error_code
);
  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_BST = 3'b110, C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;
  logic [15:0] r_mem [2**AW];
  logic [3:0] r_act;
  logic [ROW_BITS-1:0] r_row [4];
  logic r_mvalid, r_cl3, r_dqm;
  logic [1:0] r_bl;
  logic r_bst, r_brd, r_bap;
  logic [1:0] r_bbank;
  logic [COL_BITS-1:0] r_bcol, r_bmask;
  logic [2:0] r_bcnt;
  logic r_p1v, r_p2v;
  logic [15:0] r_p1d, r_p2d;
  logic [3:0] r_pend;
  logic [2:0] w_cmd;
  logic w_bact, w_bad, w_ok, w_new, w_stop, w_gen, w_grd, w_gap, w_last, w_ov;
  logic [3:0] w_code;
  logic [1:0] w_gbank;
  logic [COL_BITS-1:0] w_gcol, w_mask;
  logic [2:0] w_rem;
  logic [AW-1:0] w_gaddr;
  logic [15:0] w_od;
  // w_gen/w_g* describe the burst word handled on this edge: a new READ/WRITE preempts the running burst
  always_comb begin
    w_cmd = (dram_cke && !dram_cs_n) ? {dram_ras_n, dram_cas_n, dram_we_n} : C_NOP;
    w_bact = r_act[dram_ba];
    w_bad = dram_addr[2] || dram_addr[3] || (dram_addr[6:4] != 3'd2 && dram_addr[6:4] != 3'd3);
    w_code = (w_cmd == C_NOP) ? 4'd0 :
             (!r_mvalid && w_cmd != C_LMR) ? 4'd1 :
             (w_cmd == C_ACT && w_bact) ? 4'd3 :
             ((w_cmd == C_RD || w_cmd == C_WR) && !w_bact) ? 4'd2 :
             ((w_cmd == C_REF || w_cmd == C_LMR) && |r_act) ? 4'd4 :
             (w_cmd == C_LMR && w_bad) ? 4'd5 : 4'd0;
    w_ok = w_code == 4'd0 || w_code == 4'd5;
    w_new = w_ok && (w_cmd == C_RD || w_cmd == C_WR);
    w_stop = w_ok && (w_cmd == C_BST || (w_cmd == C_PRE && (dram_addr[10] || dram_ba == r_bbank)));
    w_gen = w_new || (r_bst && !w_stop);
    w_grd = w_new ? (w_cmd == C_RD) : r_brd;
    w_gbank = w_new ? dram_ba : r_bbank;
    w_gcol = w_new ? dram_addr[COL_BITS-1:0] : r_bcol;
    w_gap = w_new ? dram_addr[10] : r_bap;
    w_mask = w_new ? COL_BITS'((4'd1 << r_bl) - 4'd1) : r_bmask;
    w_rem = w_new ? 3'((4'd1 << r_bl) - 4'd1) : r_bcnt;
    w_last = w_rem == 3'd0;
    w_gaddr = {w_gbank, r_row[w_gbank], w_gcol};
    w_ov = r_cl3 ? r_p2v : r_p1v;
    w_od = r_cl3 ? r_p2d : r_p1d;
  end
  always_ff @(posedge dram_clk)
    if (!reset && dram_cke && w_gen && !w_grd) begin
      if (!dram_ldqm) r_mem[w_gaddr][7:0] <= dram_dq_in[7:0];
      if (!dram_udqm) r_mem[w_gaddr][15:8] <= dram_dq_in[15:8];
    end
  always_ff @(posedge dram_clk)
    if (reset) begin
      dram_dq_out <= 16'd0;
      dram_dq_oe <= 1'b0;
      mode_reg <= 13'd0;
      refresh_count <= 16'd0;
      error <= 1'b0;
      error_code <= 4'd0;
      r_act <= 4'd0;
      r_row <= '{default: '0};
      r_mvalid <= 1'b0;
      r_cl3 <= 1'b0;
      r_bl <= 2'd0;
      r_dqm <= 1'b0;
      r_bst <= 1'b0;
      r_brd <= 1'b0;
      r_bap <= 1'b0;
      r_bbank <= 2'd0;
      r_bcol <= '0;
      r_bmask <= '0;
      r_bcnt <= 3'd0;
      r_p1v <= 1'b0;
      r_p2v <= 1'b0;
      r_p1d <= 16'd0;
      r_p2d <= 16'd0;
      r_pend <= 4'd0;
    end else if (dram_cke) begin
      // read words queue through p1 (CL2) or p1->p2 (CL3); DQM seen one edge earlier blanks the output
      r_dqm <= dram_ldqm || dram_udqm;
      r_p1v <= w_gen && w_grd;
      r_p1d <= r_mem[w_gaddr];
      r_p2v <= r_p1v;
      r_p2d <= r_p1d;
      dram_dq_oe <= w_ov && !r_dqm;
      dram_dq_out <= w_ov ? w_od : 16'd0;
      r_bst <= w_gen && !w_last;
      r_brd <= w_grd;
      r_bbank <= w_gbank;
      r_bap <= w_gap;
      r_bmask <= w_mask;
      r_bcnt <= w_rem - 3'd1;
      r_bcol <= (w_gcol & ~w_mask) | ((w_gcol + COL_BITS'(1)) & w_mask);
      // error reported one edge after the offending command
      r_pend <= w_code;
      if (!error && r_pend != 4'd0) begin
        error <= 1'b1;
        error_code <= r_pend;
      end
      if (w_ok && w_cmd == C_ACT) begin
        r_act[dram_ba] <= 1'b1;
        r_row[dram_ba] <= dram_addr[ROW_BITS-1:0];
      end
      if (w_ok && w_cmd == C_PRE) r_act <= dram_addr[10] ? 4'd0 : r_act & ~(4'd1 << dram_ba);
      if (w_gen && w_last && w_gap) r_act[w_gbank] <= 1'b0;
      if (w_ok && w_cmd == C_LMR) begin
        mode_reg <= dram_addr;
        r_mvalid <= 1'b1;
        r_bl <= dram_addr[1:0];
        r_cl3 <= dram_addr[6:4] == 3'd3;
      end
      if (w_ok && w_cmd == C_REF) refresh_count <= refresh_count + 16'd1;
    end
endmodule
